apb_master2: RTL and testbench
==============================

Name: apb_master2

Overview:
- APB requester (initiator) for the peripheral subsystem.
- Converts a simple valid/ready command interface into APB3 SETUP/ACCESS transfers.
- Drives two APB completers (slave1, slave2) on a shared address/data bus, with one PSEL per completer.
- Returns read data, completion and error status on a one-cycle response strobe; a wait-state timeout aborts hung transfers.

Parameters:
- DATAWIDTH, 8, width of PWDATA/PRDATA and command/response data.
- ADDRWIDTH, 8, width of PADDR; the command address carries one extra MSB as completer select.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDRWIDTH+1  MSB selects completer (0=slave1, 1=slave2); low bits go to PADDR.
- cmd_wdata  in  DATAWIDTH  write data.
- PSEL1  out  1  select for slave1.
- PSEL2  out  1  select for slave2.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDRWIDTH  APB address.
- PWDATA  out  DATAWIDTH  APB write data.
- PRDATA1  in  DATAWIDTH  read data from slave1.
- PRDATA2  in  DATAWIDTH  read data from slave2.
- PREADY1  in  1  ready from slave1.
- PREADY2  in  1  ready from slave2.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATAWIDTH  captured read data; 0 for writes and errors.
- rsp_err  out  1  1 = transfer aborted by timeout; valid with rsp_valid.

Behaviour:
- Reset (async, PRESETn low):
  - state=IDLE.
  - PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0.
  - Wait counter = 0. cmd_ready is 0 while PRESETn is low.
- All outputs are registered except cmd_ready, which is combinational: (state==IDLE) && PRESETn.
- State machine:
  - IDLE: cmd_ready=1.
    - On accept: latch cmd_write→PWRITE, cmd_addr[ADDRWIDTH-1:0]→PADDR, cmd_wdata→PWDATA (PWDATA loaded for reads too, ignored by completer).
    - Assert the PSEL chosen by cmd_addr[ADDRWIDTH]; go to SETUP.
  - SETUP: exactly one cycle. PSELx=1, PENABLE=0. Next edge: PENABLE=1, go to ACCESS, clear counter.
  - ACCESS: PSELx=1, PENABLE=1.
    - PREADY is the selected completer's PREADYx; the unselected PREADY and PRDATA are ignored.
    - If PREADY=1 at the rising edge:
      - Transfer completes; PSELx, PENABLE → 0; go to IDLE.
      - Next cycle: rsp_valid=1, rsp_err=0.
      - rsp_rdata = selected PRDATAx sampled at that edge for reads, 0 for writes.
    - Else, if TIMEOUT!=0 and counter == TIMEOUT-1:
      - Abort; PSELx, PENABLE → 0; go to IDLE.
      - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - Else: increment counter; address, data, PWRITE and PSEL held stable.
- Latency: accept at edge N; SETUP in cycle N+1; ACCESS from N+2. With zero wait states, rsp_valid is high in cycle N+3.
- Back-to-back commands:
  - rsp_valid and cmd_ready are both high in the first IDLE cycle after completion, so the next command is accepted there.
  - Minimum 3 cycles per transfer.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata holds its value until the next response.
- PADDR, PWRITE and PWDATA hold their last values in IDLE. PSEL1 and PSEL2 are never both high.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps into a false timeout.
- Reset mid-transfer: immediate return to the reset state, with no response pulse. The first command after reset release is accepted normally.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
1. Write slave1 zero-wait: cmd_addr=0x012, wdata=0xA5.
   - PSEL1 high 2 cycles; PENABLE high 1 cycle; PADDR=0x12, PWRITE=1.
   - rsp_valid pulse at N+3 with err=0, rdata=0.
2. Read slave2: cmd_addr=0x112, PRDATA2=0x3C driven in ACCESS.
   - PSEL2 asserted, PSEL1 stays 0.
   - rsp_rdata=0x3C, rsp_err=0.
3. Wait states: PREADY1 held low 3 ACCESS cycles, then high; read with PRDATA1=0x77.
   - ACCESS lasts 4 cycles with PADDR/PSEL stable.
   - rsp_rdata=0x77.
4. Timeout (TIMEOUT=16): PREADY2 stuck low.
   - Abort after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rdata=0; bus returns idle.
5. Back-to-back write then read with cmd_valid held high.
   - Second command accepted in the same cycle as the first rsp_valid.
   - PSEL gap exactly 1 cycle.
6. PRESETn asserted during ACCESS.
   - All outputs 0 asynchronously, no rsp_valid.
   - After release, a new read completes normally.

Source files
------------

// File: rtl/apb_master2_if.sv
// ============================================================================
// Module   : apb_master2_if
// Brief    : Command/response handshake plus dual-completer APB3 bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master2_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
);

  // command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH:0]   cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;

  // shared APB request bus, one select per completer
  logic                 PSEL1;
  logic                 PSEL2;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;

  // per-completer return paths
  logic [DATAWIDTH-1:0] PRDATA1;
  logic [DATAWIDTH-1:0] PRDATA2;
  logic                 PREADY1;
  logic                 PREADY2;

  // response strobe
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready,
    output PSEL1,
    output PSEL2,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PRDATA1,
    input  PRDATA2,
    input  PREADY1,
    input  PREADY2,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready,
    input  PSEL1,
    input  PSEL2,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA1,
    output PRDATA2,
    output PREADY1,
    output PREADY2,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/apb_master2.sv
// ============================================================================
// Module   : apb_master2
// Brief    : APB3 requester turning valid/ready commands into SETUP/ACCESS
//            transfers on two completers, with a wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master2 #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  wire logic     PCLK,
  input  wire logic     PRESETn,
  apb_master2_if.master bus
);

  localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_psel1;
  logic                 r_psel2;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDRWIDTH-1:0] r_paddr;
  logic [DATAWIDTH-1:0] r_pwdata;
  logic                 r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_rdata;
  logic                 r_rsp_err;

  logic                 w_accept;
  logic                 w_pready;
  logic [DATAWIDTH-1:0] w_prdata;
  logic                 w_timeout;

  assign bus.cmd_ready = (r_state == S_IDLE) && PRESETn;
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;

  // only the selected completer's return path is ever observed
  assign w_pready = r_psel2 ? bus.PREADY2 : bus.PREADY1;
  assign w_prdata = r_psel2 ? bus.PRDATA2 : bus.PRDATA1;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = (r_cnt == c_CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_psel1     <= 1'b0;
      r_psel2     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr[ADDRWIDTH-1:0];
            r_pwdata <= bus.cmd_wdata;
            r_psel1  <= ~bus.cmd_addr[ADDRWIDTH];
            r_psel2  <=  bus.cmd_addr[ADDRWIDTH];
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_pready) begin
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : w_prdata;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_IDLE;
          end else if (r_cnt != {c_CW{1'b1}}) begin
            // saturate so a long stall can never wrap back into a match
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_psel1   <= 1'b0;
          r_psel2   <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.PSEL1     = r_psel1;
  assign bus.PSEL2     = r_psel2;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_master2.sv
// ============================================================================
// Module   : tb_apb_master2
// Brief    : Scoreboard bench for apb_master2 with memory-backed completers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master2;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic PCLK;
  logic PRESETn;

  apb_master2_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  apb_master2 #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) u_dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  typedef struct {
    logic       wr;
    logic       sel;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         w;
    int         rsp_cyc;
  } xact_t;

  xact_t      slv_q[$];
  xact_t      rsp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_accept = 0;
  logic [7:0] refm [2][256];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // completer model: memory-backed, wait states taken from the transfer record
  xact_t      cur;
  bit         active = 0;
  int         k = 0;
  bit         mem_init = 0;
  logic [7:0] mem [2][256];

  always @(negedge PCLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] = 8'(i * 3 + 1);
        mem[1][i] = ~8'(i);
      end
      mem_init = 1;
    end
    bus.PREADY1 = 1'($urandom);
    bus.PREADY2 = 1'($urandom);
    bus.PRDATA1 = 8'($urandom);
    bus.PRDATA2 = 8'($urandom);
    if (!PRESETn) begin
      active = 0;
    end else if ((bus.PSEL1 || bus.PSEL2) && !bus.PENABLE) begin
      if (slv_q.size() == 0) begin
        fail("setup_unexpected");
      end else begin
        cur    = slv_q.pop_front();
        active = 1;
        k      = 0;
        chk("setup_psel", {30'd0, bus.PSEL2, bus.PSEL1}, cur.sel ? 32'd2 : 32'd1);
        chk("setup_paddr", {24'd0, bus.PADDR}, {24'd0, cur.addr});
        chk("setup_pwrite", {31'd0, bus.PWRITE}, {31'd0, cur.wr});
        if (cur.wr) chk("setup_pwdata", {24'd0, bus.PWDATA}, {24'd0, cur.wdata});
      end
    end else if (bus.PENABLE && active) begin
      chk("access_psel", {30'd0, bus.PSEL2, bus.PSEL1}, cur.sel ? 32'd2 : 32'd1);
      chk("access_paddr", {24'd0, bus.PADDR}, {24'd0, cur.addr});
      chk("access_pwrite", {31'd0, bus.PWRITE}, {31'd0, cur.wr});
      if (k == cur.w) begin
        if (cur.wr) mem[cur.sel][cur.addr] = cur.wdata;
        if (cur.sel) begin
          bus.PREADY2 = 1'b1;
          if (!cur.wr) bus.PRDATA2 = mem[1][cur.addr];
        end else begin
          bus.PREADY1 = 1'b1;
          if (!cur.wr) bus.PRDATA1 = mem[0][cur.addr];
        end
        active = 0;
      end else begin
        if (cur.sel) bus.PREADY2 = 1'b0;
        else         bus.PREADY1 = 1'b0;
      end
      k++;
    end
  end

  // response monitor
  xact_t e;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      chk("psel_exclusive", {31'd0, bus.PSEL1 & bus.PSEL2}, 32'd0);
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e.rdata});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.rsp_cyc);
          chk("rsp_bus_idle", {29'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE}, 32'd0);
        end
      end else if (rsp_q.size() != 0 && cyc > rsp_q[0].rsp_cyc) begin
        fail("rsp_missing");
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic wr, input logic sel, input logic [7:0] a,
                       input logic [7:0] d, input int w);
    xact_t x;
    int    n = 0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = {sel, a};
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.cmd_ready) begin
      fail("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      return;
    end
    x.wr    = wr;
    x.sel   = sel;
    x.addr  = a;
    x.wdata = d;
    x.w     = w;
    x.err   = (w >= TO);
    x.rdata = (x.err || wr) ? 8'h00 : refm[sel][a];
    if (!x.err && wr) refm[sel][a] = d;
    last_accept = cyc + 1;
    x.rsp_cyc   = last_accept + (x.err ? 1 + TO : 2 + w);
    slv_q.push_back(x);
    rsp_q.push_back(x);
    @(posedge PCLK);
  endtask

  task automatic idle_cmd(input int n);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_psel"}, {30'd0, bus.PSEL1, bus.PSEL2}, 32'd0);
    chk({tag, "_penable_pwrite"}, {30'd0, bus.PENABLE, bus.PWRITE}, 32'd0);
    chk({tag, "_paddr_pwdata"}, {16'd0, bus.PADDR, bus.PWDATA}, 32'd0);
    chk({tag, "_rsp"}, {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
  endtask

  initial begin
    int a1;
    int n;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      refm[0][i] = 8'(i * 3 + 1);
      refm[1][i] = ~8'(i);
    end

    repeat (3) @(negedge PCLK);
    check_zero("reset");
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // directed scenarios
    issue(1'b1, 1'b0, 8'h12, 8'hA5, 0);
    idle_cmd(2);
    issue(1'b1, 1'b1, 8'h12, 8'h3C, 0);
    issue(1'b0, 1'b1, 8'h12, 8'h00, 0);
    idle_cmd(1);
    issue(1'b1, 1'b0, 8'h20, 8'h77, 0);
    issue(1'b0, 1'b0, 8'h20, 8'h00, 3);
    idle_cmd(1);
    issue(1'b0, 1'b1, 8'h05, 8'h00, 1000);
    issue(1'b0, 1'b0, 8'h06, 8'h00, TO - 1);
    idle_cmd(1);

    // back-to-back: next accept on the edge right after the response edge
    issue(1'b1, 1'b0, 8'h30, 8'h11, 0);
    a1 = last_accept;
    issue(1'b0, 1'b0, 8'h30, 8'h00, 0);
    chk("b2b_accept_cycle", last_accept, a1 + 3);
    idle_cmd(4);

    // reset during ACCESS, then a normal read
    issue(1'b0, 1'b1, 8'h40, 8'h00, 10);
    idle_cmd(3);
    #2 PRESETn = 1'b0;
    rsp_q.delete();
    slv_q.delete();
    #1 check_zero("midreset");
    repeat (3) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    issue(1'b0, 1'b1, 8'h40, 8'h00, 1);
    idle_cmd(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      int w;
      r = int'($urandom_range(0, 19));
      w = (r == 0) ? 1000 : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 8'($urandom), w);
      if ($urandom_range(0, 2) == 0) idle_cmd(int'($urandom_range(0, 3)));
    end
    idle_cmd(0);

    n = 0;
    while (rsp_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (rsp_q.size() != 0) fail("drain_timeout");
    repeat (2) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
